// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset release sequencer.
// Staggered power-on release plus masked soft-reset with req/ack.
module rst_seq_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYC    = 8,
    parameter int STAGGER_CYC = 4,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              sw_req,
    input  logic [NUM_CH-1:0] sw_mask,
    output logic              sw_ack,
    output logic [NUM_CH-1:0] rstn_o,
    output logic              done,
    output logic              busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE      = NUM_CH'(1);

    if (NUM_CH < 1 || HOLD_CYC < 1 || STAGGER_CYC < 1 ||
        HOLD_CYC >= 2**CNT_W || STAGGER_CYC >= 2**CNT_W) begin : g_param_err
        $error("rst_seq_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        DONE,
        SOFT_HOLD
    } state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [NUM_CH-1:0] m_q, m_n;
    logic [NUM_CH-1:0] rst_q, rst_n;
    logic              done_q, done_n;
    logic              ack_q, ack_n;

    // State and output registers; RSTN low aborts everything to ASSERT.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            m_q     <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            m_q     <= m_n;
            rst_q   <= rst_n;
            done_q  <= done_n;
            ack_q   <= ack_n;
        end
    end

    // Next-state: hold count, staggered release, soft-reset accept/hold.
    // A request is not re-accepted while the previous ack is high,
    // which gives the every-other-cycle ack for a held zero mask.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        m_n     = m_q;
        rst_n   = rst_q;
        done_n  = done_q;
        ack_n   = 1'b0;
        unique case (state_q)
            ASSERT: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == STAG_LAST) begin
                    rst_n = rst_q | (ONE << idx_q);
                    cnt_n = '0;
                    if (idx_q == IDX_LAST) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (sw_req && !ack_q) begin
                    ack_n = 1'b1;
                    m_n   = sw_mask;
                    if (|sw_mask) begin
                        rst_n   = rst_q & ~sw_mask;
                        done_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = SOFT_HOLD;
                    end
                end
            end
            SOFT_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    rst_n   = rst_q | m_q;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = ASSERT;
        endcase
    end

    assign rstn_o = rst_q;
    assign done   = done_q;
    assign busy   = ~done_q;
    assign sw_ack = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: default-parameter table plus a
// minimal NUM_CH=1/HOLD=1/STAGGER=1 instance checked by hand.
module tb_rst_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       sw_req = 1'b0;
    logic [3:0] sw_mask = '0;
    logic       sw_ack;
    logic [3:0] rstn_o;
    logic       done;
    logic       busy;

    logic       rstn1 = 1'b0;
    logic       req1 = 1'b0;
    logic [0:0] mask1 = '0;
    logic       ack1;
    logic [0:0] o1;
    logic       done1;
    logic       busy1;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    rst_seq_ctrl dut (
        .CLK(CLK), .RSTN(RSTN), .sw_req(sw_req), .sw_mask(sw_mask),
        .sw_ack(sw_ack), .rstn_o(rstn_o), .done(done), .busy(busy)
    );

    rst_seq_ctrl #(
        .NUM_CH(1), .HOLD_CYC(1), .STAGGER_CYC(1), .CNT_W(8)
    ) dut1 (
        .CLK(CLK), .RSTN(rstn1), .sw_req(req1), .sw_mask(mask1),
        .sw_ack(ack1), .rstn_o(o1), .done(done1), .busy(busy1)
    );

    typedef struct {
        logic       rstn;
        logic       req;
        logic [3:0] mask;
        int         n;
        logic [3:0] o;
        logic       d;
        logic       a;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string name, input logic e_o,
                        input logic e_d, input logic e_a);
        n_vec++;
        if ({o1, done1, busy1, ack1} !== {e_o, e_d, ~e_d, e_a}) begin
            n_err++;
            $display("FAIL %s: got o=%b done=%b busy=%b ack=%b need o=%b done=%b busy=%b ack=%b",
                     name, o1, done1, busy1, ack1, e_o, e_d, ~e_d, e_a);
        end
    endtask

    initial begin
        // power-on / restart, soft reset, ignored req, zero-mask acks
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 3,  4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 11, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 2,  4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'b1111, 1,  4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1,  4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4,  4'b0011, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4,  4'b0111, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'b0101, 1,  4'b1010, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 7,  4'b1010, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'b0000, 1,  4'b1111, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'b0000, 1,  4'b1111, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});
        // abort in soft-hold cycle 3, then full restart
        tbl.push_back('{1'b1, 1'b1, 4'b0011, 1,  4'b1100, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 2,  4'b1100, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 1,  4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 11, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4,  4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4,  4'b0011, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4,  4'b0111, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});
        // req held through soft-hold: re-accepted right after return
        tbl.push_back('{1'b1, 1'b1, 4'b0001, 1,  4'b1110, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 4'b0001, 7,  4'b1110, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'b0001, 1,  4'b1111, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'b0001, 1,  4'b1110, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 7,  4'b1110, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1,  4'b1111, 1'b1, 1'b0});

        // minimal instance: release on edge 2, one-cycle soft hold
        step();
        chk1("min_reset_a", 1'b0, 1'b0, 1'b0);
        step();
        chk1("min_reset_b", 1'b0, 1'b0, 1'b0);
        rstn1 = 1'b1;
        step();
        chk1("min_edge1", 1'b0, 1'b0, 1'b0);
        step();
        chk1("min_edge2", 1'b1, 1'b1, 1'b0);
        req1  = 1'b1;
        mask1 = 1'b1;
        step();
        chk1("min_soft_ack", 1'b0, 1'b0, 1'b1);
        req1  = 1'b0;
        mask1 = 1'b0;
        step();
        chk1("min_soft_rel", 1'b1, 1'b1, 1'b0);
        step();
        chk1("min_idle", 1'b1, 1'b1, 1'b0);

        // main instance table
        foreach (tbl[r]) begin
            RSTN    = tbl[r].rstn;
            sw_req  = tbl[r].req;
            sw_mask = tbl[r].mask;
            for (int c = 0; c < tbl[r].n; c++) begin
                step();
                n_vec++;
                if ({rstn_o, done, busy, sw_ack} !==
                    {tbl[r].o, tbl[r].d, ~tbl[r].d, tbl[r].a}) begin
                    n_err++;
                    $display("FAIL row%0d cyc%0d: got o=%b done=%b busy=%b ack=%b need o=%b done=%b busy=%b ack=%b",
                             r, c, rstn_o, done, busy, sw_ack,
                             tbl[r].o, tbl[r].d, ~tbl[r].d, tbl[r].a);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
